figure_sorter: RTL and testbench
================================

# figure_sorter

Sequential, parametrised cell-coordinate normaliser for the tetris datapath. It accepts one figure, given as CELLS packed (x, y) cell coordinates, and sorts the cells into ascending row-major order (key {y, x}) using odd-even transposition. The result is returned with bounding-box and duplicate-cell flags. It sits between figure generation/rotation and the collision/draw logic, and extends the old I-figure-only reorder to any figure and any cell count.

## Interface
Parameters:
- WIDTH, 8, bits per coordinate and per figure code
- CELLS, 4, cells per figure; must be at least 2

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input figure offered
- in_ready  out  1  block can accept; high only in IDLE
- sort_en  in  1  sampled at accept; 0 means pass through unsorted
- figure  in  WIDTH  figure code, carried through unchanged
- rho_x, rho_y  in  CELLS*WIDTH  cell i occupies bits [(i+1)*WIDTH-1 : i*WIDTH]
- out_valid  out  1  result held stable until accepted
- out_ready  in  1  downstream accepts
- out_figure  out  WIDTH  captured figure code
- out_rho_x, out_rho_y  out  CELLS*WIDTH  sorted (or passed-through) cells
- min_x, max_x, min_y, max_y  out  WIDTH each  bounding box of the cells, unsigned
- dup  out  1  two cells have identical (x, y)

## Operation
- FSM states are IDLE, SORT and DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid && in_ready, capture figure, rho_x, rho_y and sort_en.
  - If sort_en = 1, go to SORT with phase counter 0. If sort_en = 0, go to DONE.
- SORT, one phase per cycle:
  - An even phase compare-swaps pairs (0,1), (2,3), and so on.
  - An odd phase compare-swaps pairs (1,2), (3,4), and so on.
  - A pair swaps only when key(lower index) > key(higher index), strictly. This makes the sort stable.
  - The key is {y, x}, compared unsigned as 2*WIDTH bits.
  - After phase CELLS-1, go to DONE.
- DONE:
  - out_valid = 1. All out_* signals are held constant.
  - On out_valid && out_ready, go to IDLE.
- min/max outputs: combinational unsigned reductions over the registered cell array. They are valid whenever out_valid is high.
- dup: high if any two cells are equal.
  - Sorted path: compute it from adjacent pairs.
  - Bypass path: compute it from a full pairwise compare.
  - Only the full pairwise compare is required, and it is valid for both paths.
- Legacy equivalence: a vertical I (equal x) comes out ordered by ascending y; a horizontal I (equal y) comes out ordered by ascending x.
- Inputs are ignored outside IDLE. in_valid held high during SORT or DONE has no effect.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0. All cell, figure, bound and dup registers/outputs are 0.
- Sorted latency: accept on edge k, phases on edges k+1 through k+CELLS, out_valid high after edge k+CELLS.
- Bypass latency: out_valid high after edge k+1.
- Throughput: no overlap, because in_ready is low in SORT and DONE. With out_ready held high, the minimum accept-to-accept interval is CELLS+2 cycles.
- Backpressure: DONE may last any number of cycles. Outputs must not change while out_valid && !out_ready.
- Output acceptance and new-input acceptance never share a cycle. in_ready rises the cycle after the out handshake.
- Reset mid-SORT or mid-DONE: immediate return to IDLE, out_valid drops asynchronously, and the partial result is discarded.
- Width rules:
  - Phase counter width is $clog2(CELLS)+1.
  - There is no coordinate arithmetic beyond compares, so there is no overflow.
  - Coordinates of all 1s are legal.

## Structure
- Shared tetris package holds:
  - figure code constants (FIG_I = 0, and the others)
  - the state enum {IDLE, SORT, DONE}
  - the default CELLS = 4
- Sub-module cell_cmp_swap: one compare-exchange on two (x, y) pairs plus an enable. It is instantiated CELLS-1 times and selected by phase parity.

## Test plan
All scenarios use WIDTH = 8, CELLS = 4.
- Reversed vertical I, sort_en = 1:
  - Stimulus: x = {5,5,5,5}, y (cell0..3) = {3,2,1,0}.
  - Response: out_valid on cycle 4 after accept, out_rho_y = {0,1,2,3}, min_y = 0, max_y = 3, min_x = max_x = 5, dup = 0.
- Reversed horizontal I:
  - Stimulus: x = {9,8,7,6}, y = {2,2,2,2}.
  - Response: x = {6,7,8,9}. This matches the legacy reorder.
- T figure, scrambled:
  - Stimulus: (x, y) = (4,1), (3,0), (5,0), (4,0).
  - Response: (3,0), (4,0), (5,0), (4,1), with bounds x 3..5 and y 0..1.
- Duplicate cells, in bypass:
  - Stimulus: cells (2,2), (2,2), (3,2), (4,2) with sort_en = 0.
  - Response: out_valid after 1 cycle, cells unchanged, dup = 1.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles in DONE while in_valid is held high.
  - Response: outputs stable and in_ready = 0. After out_ready pulses, in_ready = 1 on the next cycle and the next figure is accepted.
- Reset mid-sort:
  - Stimulus: drop rst_n at phase 2.
  - Response: out_valid = 0, outputs zero, in_ready = 1. A new figure after reset sorts correctly.

Source files
------------

// File: rtl/figure_sorter_pkg.sv
// rtl/figure_sorter_pkg.sv - shared tetris figure codes, FSM states and sorter defaults
package figure_sorter_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CELLS = 4;

  localparam int FIG_I = 0;
  localparam int FIG_O = 1;
  localparam int FIG_T = 2;
  localparam int FIG_S = 3;
  localparam int FIG_Z = 4;
  localparam int FIG_J = 5;
  localparam int FIG_L = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/figure_sorter_cell_cmp_swap.sv
// rtl/figure_sorter_cell_cmp_swap.sv - one compare-exchange of two (x, y) cells on key {y, x}
module cell_cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_lo_x,
  input  logic [WIDTH-1:0] i_lo_y,
  input  logic [WIDTH-1:0] i_hi_x,
  input  logic [WIDTH-1:0] i_hi_y,
  output logic [WIDTH-1:0] o_lo_x,
  output logic [WIDTH-1:0] o_lo_y,
  output logic [WIDTH-1:0] o_hi_x,
  output logic [WIDTH-1:0] o_hi_y
);

  logic w_swap;

  // Strict compare keeps equal keys in place, which makes the whole sort stable.
  assign w_swap = i_en && ({i_lo_y, i_lo_x} > {i_hi_y, i_hi_x});

  assign o_lo_x = w_swap ? i_hi_x : i_lo_x;
  assign o_lo_y = w_swap ? i_hi_y : i_lo_y;
  assign o_hi_x = w_swap ? i_lo_x : i_hi_x;
  assign o_hi_y = w_swap ? i_lo_y : i_hi_y;

endmodule

// File: rtl/figure_sorter.sv
// rtl/figure_sorter.sv - odd-even transposition sort of figure cells into row-major order
module figure_sorter
  import figure_sorter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CELLS = DEF_CELLS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sort_en,
  input  logic [WIDTH-1:0]       figure,
  input  logic [CELLS*WIDTH-1:0] rho_x,
  input  logic [CELLS*WIDTH-1:0] rho_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_figure,
  output logic [CELLS*WIDTH-1:0] out_rho_x,
  output logic [CELLS*WIDTH-1:0] out_rho_y,
  output logic [WIDTH-1:0]       min_x,
  output logic [WIDTH-1:0]       max_x,
  output logic [WIDTH-1:0]       min_y,
  output logic [WIDTH-1:0]       max_y,
  output logic                   dup
);

  localparam int PW = $clog2(CELLS) + 1;

  logic [1:0]                        r_state;
  logic [PW-1:0]                     r_phase;
  logic                              r_sort_en;
  logic [WIDTH-1:0]                  r_fig;
  logic [CELLS-1:0][WIDTH-1:0]       r_x;
  logic [CELLS-1:0][WIDTH-1:0]       r_y;

  logic [CELLS-2:0][WIDTH-1:0]       w_lo_x, w_lo_y, w_hi_x, w_hi_y;
  logic [CELLS-1:0][WIDTH-1:0]       w_nx, w_ny;
  logic [WIDTH-1:0]                  w_min_x, w_max_x, w_min_y, w_max_y;
  logic                              w_dup;

  // Pair p joins the phase whose parity equals p's parity.
  for (genvar p = 0; p < CELLS - 1; p++) begin : g_pair
    localparam logic PPAR = 1'(p % 2);
    cell_cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
      .i_en   (r_sort_en && (r_phase[0] == PPAR)),
      .i_lo_x (r_x[p]),
      .i_lo_y (r_y[p]),
      .i_hi_x (r_x[p+1]),
      .i_hi_y (r_y[p+1]),
      .o_lo_x (w_lo_x[p]),
      .o_lo_y (w_lo_y[p]),
      .o_hi_x (w_hi_x[p]),
      .o_hi_y (w_hi_y[p])
    );
  end

  // Cell j is the low side of pair j or the high side of pair j-1, never both in one phase.
  for (genvar j = 0; j < CELLS; j++) begin : g_next
    localparam logic JPAR = 1'(j % 2);
    if (j == 0) begin : g_first
      assign w_nx[j] = (r_phase[0] == JPAR) ? w_lo_x[j] : r_x[j];
      assign w_ny[j] = (r_phase[0] == JPAR) ? w_lo_y[j] : r_y[j];
    end else if (j == CELLS - 1) begin : g_last
      assign w_nx[j] = (r_phase[0] != JPAR) ? w_hi_x[j-1] : r_x[j];
      assign w_ny[j] = (r_phase[0] != JPAR) ? w_hi_y[j-1] : r_y[j];
    end else begin : g_mid
      assign w_nx[j] = (r_phase[0] == JPAR) ? w_lo_x[j] : w_hi_x[j-1];
      assign w_ny[j] = (r_phase[0] == JPAR) ? w_lo_y[j] : w_hi_y[j-1];
    end
  end

  // Bypass also spends one cycle in SORT (swaps disabled) so its result lands one edge after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_sort_en <= 1'b0;
      r_fig     <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_fig     <= figure;
            r_x       <= rho_x;
            r_y       <= rho_y;
            r_sort_en <= sort_en;
            r_phase   <= '0;
            r_state   <= ST_SORT;
          end
        end
        ST_SORT: begin
          r_x     <= w_nx;
          r_y     <= w_ny;
          r_phase <= r_phase + PW'(1);
          if (!r_sort_en || (r_phase == PW'(CELLS - 1))) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_min_x = r_x[0];
    w_max_x = r_x[0];
    w_min_y = r_y[0];
    w_max_y = r_y[0];
    w_dup   = 1'b0;
    for (int i = 1; i < CELLS; i++) begin
      if (r_x[i] < w_min_x) w_min_x = r_x[i];
      if (r_x[i] > w_max_x) w_max_x = r_x[i];
      if (r_y[i] < w_min_y) w_min_y = r_y[i];
      if (r_y[i] > w_max_y) w_max_y = r_y[i];
    end
    for (int a = 0; a < CELLS - 1; a++) begin
      for (int b = a + 1; b < CELLS; b++) begin
        if ((r_x[a] == r_x[b]) && (r_y[a] == r_y[b])) w_dup = 1'b1;
      end
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_figure = r_fig;
  assign out_rho_x  = r_x;
  assign out_rho_y  = r_y;
  assign min_x      = w_min_x;
  assign max_x      = w_max_x;
  assign min_y      = w_min_y;
  assign max_y      = w_max_y;
  // The zeroed reset cells all coincide, so the flag is only meaningful with a result present.
  assign dup        = out_valid && w_dup;

endmodule

// File: tb/tb_figure_sorter.sv
// tb/tb_figure_sorter.sv - randomized self-checking bench for figure_sorter against a stable-sort model
module tb_figure_sorter;
  import figure_sorter_pkg::*;

  localparam int W = 8;
  localparam int C = 4;

  logic           clk, rst_n;
  logic           in_valid, in_ready, sort_en, out_valid, out_ready, dup;
  logic [W-1:0]   figure, out_figure, min_x, max_x, min_y, max_y;
  logic [C*W-1:0] rho_x, rho_y, out_rho_x, out_rho_y;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0]   tx [C];
  logic [W-1:0]   ty [C];
  logic [C*W-1:0] e_x, e_y;
  logic [4*W-1:0] e_box;
  logic           e_dup;

  figure_sorter #(.WIDTH(W), .CELLS(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sort_en(sort_en), .figure(figure), .rho_x(rho_x), .rho_y(rho_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_figure(out_figure),
    .out_rho_x(out_rho_x), .out_rho_y(out_rho_y),
    .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y), .dup(dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: stable insertion sort on row-major key, bounds and pairwise duplicates.
  task automatic model(input logic sen);
    logic [W-1:0] sx [C];
    logic [W-1:0] sy [C];
    logic [W-1:0] t;
    int mnx, mxx, mny, mxy, j;
    for (int i = 0; i < C; i++) begin sx[i] = tx[i]; sy[i] = ty[i]; end
    if (sen) begin
      for (int i = 1; i < C; i++) begin
        j = i;
        while (j > 0 && (int'(sy[j-1]) * 256 + int'(sx[j-1])) > (int'(sy[j]) * 256 + int'(sx[j]))) begin
          t = sx[j]; sx[j] = sx[j-1]; sx[j-1] = t;
          t = sy[j]; sy[j] = sy[j-1]; sy[j-1] = t;
          j--;
        end
      end
    end
    mnx = 255; mxx = 0; mny = 255; mxy = 0; e_dup = 1'b0;
    for (int i = 0; i < C; i++) begin
      e_x[i*W +: W] = sx[i];
      e_y[i*W +: W] = sy[i];
      if (tx[i] < mnx) mnx = tx[i];
      if (tx[i] > mxx) mxx = tx[i];
      if (ty[i] < mny) mny = ty[i];
      if (ty[i] > mxy) mxy = ty[i];
      for (int k = i + 1; k < C; k++)
        if (tx[i] == tx[k] && ty[i] == ty[k]) e_dup = 1'b1;
    end
    e_box = {W'(mnx), W'(mxx), W'(mny), W'(mxy)};
  endtask

  task automatic offer(input logic sen, input logic [W-1:0] fig);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 100) begin @(posedge clk); #1; cnt++; end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    for (int i = 0; i < C; i++) begin rho_x[i*W +: W] = tx[i]; rho_y[i*W +: W] = ty[i]; end
    sort_en  = sen;
    figure   = fig;
    in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_fig(input logic sen, input logic [W-1:0] fig, input int bp, input logic hold_valid);
    int  cnt;
    logic stable;
    model(sen);
    offer(sen, fig);
    if (!hold_valid) in_valid = 1'b0;
    rho_x   = $urandom;
    rho_y   = $urandom;
    figure  = W'($urandom);
    sort_en = ~sen;
    cnt = 0;
    while (!out_valid && cnt < 50) begin @(posedge clk); #1; cnt++; end
    check("latency", 64'(cnt), sen ? 64'(C) : 64'd1);
    check("out_rho_x", 64'(out_rho_x), 64'(e_x));
    check("out_rho_y", 64'(out_rho_y), 64'(e_y));
    check("out_figure", 64'(out_figure), 64'(fig));
    check("bbox", 64'({min_x, max_x, min_y, max_y}), 64'(e_box));
    check("dup", 64'(dup), 64'(e_dup));
    stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (out_rho_x !== e_x || out_rho_y !== e_y || out_figure !== fig ||
          {min_x, max_x, min_y, max_y} !== e_box || dup !== e_dup ||
          in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("after_handshake", 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sort_en = 1'b0;
    figure = '0; rho_x = '0; rho_y = '0;
    #7;
    check("reset_ctrl", 64'({in_ready, out_valid, dup}), 64'b100);
    check("reset_data", 64'({out_figure, out_rho_x, out_rho_y}), 64'd0);
    check("reset_bbox", 64'({min_x, max_x, min_y, max_y}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    tx = '{8'd5, 8'd5, 8'd5, 8'd5}; ty = '{8'd3, 8'd2, 8'd1, 8'd0};
    run_fig(1'b1, W'(FIG_I), 0, 1'b0);
    check("vert_I_y", 64'(out_rho_y), 64'h03020100);

    tx = '{8'd9, 8'd8, 8'd7, 8'd6}; ty = '{8'd2, 8'd2, 8'd2, 8'd2};
    run_fig(1'b1, W'(FIG_I), 1, 1'b0);

    tx = '{8'd4, 8'd3, 8'd5, 8'd4}; ty = '{8'd1, 8'd0, 8'd0, 8'd0};
    run_fig(1'b1, W'(FIG_T), 0, 1'b0);

    tx = '{8'd2, 8'd2, 8'd3, 8'd4}; ty = '{8'd2, 8'd2, 8'd2, 8'd2};
    run_fig(1'b0, W'(FIG_L), 0, 1'b0);

    tx = '{8'd1, 8'd0, 8'd1, 8'd0}; ty = '{8'd1, 8'd1, 8'd0, 8'd0};
    run_fig(1'b1, W'(FIG_O), 5, 1'b1);

    tx = '{8'd7, 8'd6, 8'd5, 8'd4}; ty = '{8'd3, 8'd3, 8'd3, 8'd3};
    offer(1'b1, W'(FIG_Z));
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midsort_reset_ctrl", 64'({in_ready, out_valid, dup}), 64'b100);
    check("midsort_reset_data", 64'({out_rho_x, out_rho_y, out_figure}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tx = '{8'd255, 8'd0, 8'd255, 8'd0}; ty = '{8'd255, 8'd255, 8'd0, 8'd0};
    run_fig(1'b1, W'(FIG_S), 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int mode;
      mode = $urandom_range(0, 3);
      for (int i = 0; i < C; i++) begin
        case (mode)
          0: begin tx[i] = W'($urandom_range(0, 3)); ty[i] = W'($urandom_range(0, 3)); end
          1: begin tx[i] = W'($urandom_range(250, 255)); ty[i] = W'($urandom_range(0, 1)); end
          default: begin tx[i] = W'($urandom); ty[i] = W'($urandom); end
        endcase
      end
      run_fig(1'($urandom_range(0, 1)), W'($urandom_range(0, 6)), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
